// File: rtl/cd_stream_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : cd_pkg
//  Purpose   : Shared types and defaults for the cd_stream_arbiter slice:
//              FSM state encoding, burst-length default and sample type.
//  Revision  : 1.0  initial release
// ============================================================================
package cd_pkg;

    // Arbiter grant state
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    // Default maximum beats per grant before forced re-arbitration
    localparam int BURST_MAX_DEFAULT = 8;

    // Width of one requester sample
    localparam int SAMPLE_W = 4;

    typedef logic [SAMPLE_W-1:0] sample_t;

endpackage
`default_nettype wire

// File: rtl/cd_stream_arbiter_err_counter.sv
`default_nettype none
// ============================================================================
//  Module    : cd_err_counter
//  Purpose   : Saturating event counter with synchronous clear. Clear has
//              priority over a coincident increment; the count sticks at
//              all-ones once reached.
//  Revision  : 1.0  initial release
// ============================================================================
module cd_err_counter
    import cd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    // Count increments, clearing on request and holding at full scale
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != ALL_ONES)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/cd_stream_arbiter.sv
`default_nettype none
// ============================================================================
//  Module    : cd_stream_arbiter
//  Purpose   : Two-requester burst arbiter feeding a shared external up/down
//              detector. Routes the detector's per-beat verdict back to the
//              owning requester, masks the first verdict after an owner
//              change, and keeps saturating error counts per requester.
//  Revision  : 1.0  initial release
// ============================================================================
module cd_stream_arbiter
    import cd_pkg::*;
#(
    parameter int BURST_MAX = BURST_MAX_DEFAULT,
    parameter int ERR_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  sample_t          req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  sample_t          req1_data,
    output logic             req1_ready,
    output sample_t          det_data,
    output logic             det_reset,
    input  logic             det_incr,
    input  logic             det_decr,
    input  logic             det_error,
    output logic             res_valid,
    output logic             res_id,
    output logic             res_incr,
    output logic             res_decr,
    output logic             res_error,
    output logic [ERR_W-1:0] err_cnt0,
    output logic [ERR_W-1:0] err_cnt1,
    input  logic             err_clr
);

    // beat_cnt value at which the current beat closes the burst
    localparam logic [3:0] LAST_BEAT = 4'(BURST_MAX - 1);

    state_t     state;
    logic       last_owner;
    logic [3:0] beat_cnt;

    logic       beat_d;
    logic       id_d;
    logic       first_d;
    logic       seen_beat;

    logic       owner;
    logic       owner_valid;
    logic       other_valid;
    logic       beat;
    logic       burst_done;
    logic       leave;
    logic       first;

    logic [ERR_W-1:0] err_cnt [2];

    // Readies decode straight from the grant state so reset drops them at once
    assign req0_ready  = (state == GRANT0);
    assign req1_ready  = (state == GRANT1);
    assign owner       = (state == GRANT1);
    assign owner_valid = owner ? req1_valid : req0_valid;
    assign other_valid = owner ? req0_valid : req1_valid;
    assign beat        = (req0_ready & req0_valid) | (req1_ready & req1_valid);
    assign burst_done  = beat && (beat_cnt == LAST_BEAT);
    assign leave       = !owner_valid || burst_done;

    // A beat is "first" when nothing was accepted since reset or the owner changed
    assign first = !seen_beat || (owner != id_d);

    // Detector sees only accepted beats; otherwise it is held so its last sample survives gaps
    assign det_data  = beat ? (owner ? req1_data : req0_data) : '0;
    assign det_reset = ~beat;

    // Grant FSM: arbitration, burst counting and fairness bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            beat_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    if (req0_valid && req1_valid) begin
                        state <= last_owner ? GRANT0 : GRANT1;
                    end else if (req0_valid) begin
                        state <= GRANT0;
                    end else if (req1_valid) begin
                        state <= GRANT1;
                    end
                end
                GRANT0, GRANT1: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 4'd1;
                    end
                    if (leave) begin
                        last_owner <= owner;
                        beat_cnt   <= '0;
                        if (other_valid) begin
                            state <= owner ? GRANT0 : GRANT1;
                        end else if (owner_valid && burst_done) begin
                            state <= state;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    beat_cnt <= '0;
                end
            endcase
        end
    end

    // Align beat, owner and first-beat flag with the detector's registered verdict
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_d    <= 1'b0;
            id_d      <= 1'b0;
            first_d   <= 1'b1;
            seen_beat <= 1'b0;
        end else begin
            beat_d <= beat;
            if (beat) begin
                id_d      <= owner;
                first_d   <= first;
                seen_beat <= 1'b1;
            end
        end
    end

    // A first beat compares against the other owner's sample, so its verdict is dropped
    assign res_valid = beat_d & ~first_d;
    assign res_id    = res_valid & id_d;
    assign res_incr  = res_valid & det_incr;
    assign res_decr  = res_valid & det_decr;
    assign res_error = res_valid & det_error;

    generate
        for (genvar i = 0; i < 2; i++) begin : g_err
            cd_err_counter #(
                .WIDTH (ERR_W)
            ) u_err_counter (
                .clk   (clk),
                .reset (reset),
                .clr   (err_clr),
                .inc   (res_valid & res_error & (res_id == 1'(i))),
                .count (err_cnt[i])
            );
        end
    endgenerate

    assign err_cnt0 = err_cnt[0];
    assign err_cnt1 = err_cnt[1];

endmodule
`default_nettype wire

// File: tb/tb_cd_stream_arbiter.sv
`default_nettype none
// ============================================================================
//  Module    : tb_cd_stream_arbiter
//  Purpose   : Self-checking bench for cd_stream_arbiter with a behavioural
//              model of the external up/down detector.
//  Revision  : 1.0  initial release
// ============================================================================
module tb_cd_stream_arbiter;

    localparam int K_NONE = 0;
    localparam int K_INC  = 1;
    localparam int K_DEC  = 2;
    localparam int K_ERR  = 3;
    localparam int K_MASK = 7;

    logic       clk;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic [3:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic [3:0] det_data;
    logic       det_reset;
    logic       det_incr, det_decr, det_error;
    logic       res_valid, res_id, res_incr, res_decr, res_error;
    logic [7:0] err_cnt0, err_cnt1;
    logic       err_clr;

    cd_stream_arbiter #(
        .BURST_MAX (8),
        .ERR_W     (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .det_data   (det_data),
        .det_reset  (det_reset),
        .det_incr   (det_incr),
        .det_decr   (det_decr),
        .det_error  (det_error),
        .res_valid  (res_valid),
        .res_id     (res_id),
        .res_incr   (res_incr),
        .res_decr   (res_decr),
        .res_error  (res_error),
        .err_cnt0   (err_cnt0),
        .err_cnt1   (err_cnt1),
        .err_clr    (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External detector: compares each accepted sample to the previous one (no wrap)
    logic [3:0] det_prev;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            det_prev  <= 4'd0;
            det_incr  <= 1'b0;
            det_decr  <= 1'b0;
            det_error <= 1'b0;
        end else if (det_reset) begin
            det_incr  <= 1'b0;
            det_decr  <= 1'b0;
            det_error <= 1'b0;
        end else begin
            det_incr  <= ({1'b0, det_data} == ({1'b0, det_prev} + 5'd1));
            det_decr  <= (({1'b0, det_data} + 5'd1) == {1'b0, det_prev});
            det_error <= ({1'b0, det_data} != ({1'b0, det_prev} + 5'd1)) &&
                         (({1'b0, det_data} + 5'd1) != {1'b0, det_prev});
            det_prev  <= det_data;
        end
    end

    // One cycle of stimulus plus the grant state the arbiter must be in (0 idle, 1/2 grant0/1)
    typedef struct {
        bit         rst;
        bit         v0;
        logic [3:0] d0;
        bit         v1;
        logic [3:0] d1;
        bit         clr;
        int         st;
        int         kind;
        bit         id;
        int         c0;
        int         c1;
    } vec_t;

    typedef struct {
        int kind;
        bit id;
    } res_t;

    vec_t vecs[$];
    res_t sb[$];
    int   tests  = 0;
    int   failed = 0;
    int   cur_row = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s row %0d: got %0d expected %0d", name, cur_row, act, exp);
        end
    endtask

    task automatic add(input bit rst, input bit v0, input int d0, input bit v1, input int d1,
                       input bit clr, input int st, input int kind, input bit id,
                       input int c0, input int c1);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.d0 = 4'(d0); v.v1 = v1; v.d1 = 4'(d1); v.clr = clr;
        v.st = st; v.kind = kind; v.id = id; v.c0 = c0; v.c1 = c1;
        vecs.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        bit         beat;
        logic [3:0] dd;
        res_t       pend;
        res_t       now_r;
        @(negedge clk);
        reset      = v.rst;
        req0_valid = v.v0;
        req0_data  = v.d0;
        req1_valid = v.v1;
        req1_data  = v.d1;
        err_clr    = v.clr;
        #1;
        beat = (v.st == 1 && v.v0) || (v.st == 2 && v.v1);
        dd   = !beat ? 4'd0 : ((v.st == 1) ? v.d0 : v.d1);
        check("req0_ready", int'(req0_ready), int'(v.st == 1));
        check("req1_ready", int'(req1_ready), int'(v.st == 2));
        check("det_reset",  int'(det_reset),  int'(!beat));
        check("det_data",   int'(det_data),   int'(dd));
        check("err_cnt0",   int'(err_cnt0),   v.c0);
        check("err_cnt1",   int'(err_cnt1),   v.c1);
        // Result of the previous cycle's beat; a reset wipes it
        pend.kind = K_NONE;
        pend.id   = 1'b0;
        if (sb.size() > 0) pend = sb.pop_front();
        if (v.rst) pend.kind = K_NONE;
        now_r.kind = v.rst ? K_NONE : v.kind;
        now_r.id   = v.id;
        sb.push_back(now_r);
        check("res_valid", int'(res_valid), int'(pend.kind >= K_INC && pend.kind <= K_ERR));
        if (pend.kind != K_MASK) begin
            check("res_incr",  int'(res_incr),  int'(pend.kind == K_INC));
            check("res_decr",  int'(res_decr),  int'(pend.kind == K_DEC));
            check("res_error", int'(res_error), int'(pend.kind == K_ERR));
        end
        if (pend.kind >= K_INC && pend.kind <= K_ERR) begin
            check("res_id", int'(res_id), int'(pend.id));
        end
    endtask

    initial begin
        bit tog;
        reset = 1'b1; req0_valid = 0; req1_valid = 0; req0_data = 0; req1_data = 0; err_clr = 0;

        //   rst v0 d0 v1 d1 clr st kind    id c0 c1
        add(1, 1, 3, 1, 0, 0, 0, K_NONE, 0, 0, 0);   // readys stay low under reset
        // req0 alone: 3 (masked), then incrementing stream
        add(0, 1, 3, 0, 0, 0, 0, K_NONE, 0, 0, 0);
        add(0, 1, 3, 0, 0, 0, 1, K_MASK, 0, 0, 0);
        add(0, 1, 4, 0, 0, 0, 1, K_INC,  0, 0, 0);
        add(0, 1, 5, 0, 0, 0, 1, K_INC,  0, 0, 0);
        add(0, 1, 6, 0, 0, 0, 1, K_INC,  0, 0, 0);
        add(0, 1, 7, 0, 0, 0, 1, K_INC,  0, 0, 0);
        // two-cycle valid gap, then 6 is a decrement against the held 7
        add(0, 0, 0, 0, 0, 0, 1, K_NONE, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, K_NONE, 0, 0, 0);
        add(0, 1, 6, 0, 0, 0, 0, K_NONE, 0, 0, 0);
        add(0, 1, 6, 0, 0, 0, 1, K_DEC,  0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, K_NONE, 0, 0, 0);
        // req1 sends 2 (masked, owner change) then 9 -> error on id 1
        add(0, 0, 0, 1, 2, 0, 0, K_NONE, 1, 0, 0);
        add(0, 0, 0, 1, 2, 0, 2, K_MASK, 1, 0, 0);
        add(0, 0, 0, 1, 9, 0, 2, K_ERR,  1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 2, K_NONE, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, K_NONE, 0, 0, 1);
        // req0 wraps 15 -> 0: reported as error
        add(0, 1, 15, 0, 0, 0, 0, K_NONE, 0, 0, 1);
        add(0, 1, 15, 0, 0, 0, 1, K_MASK, 0, 0, 1);
        add(0, 1, 0,  0, 0, 0, 1, K_ERR,  0, 0, 1);
        add(0, 0, 0,  0, 0, 0, 1, K_NONE, 0, 0, 1);
        add(0, 0, 0,  0, 0, 0, 0, K_NONE, 0, 1, 1);
        add(0, 0, 0,  0, 0, 1, 0, K_NONE, 0, 1, 1);
        add(0, 0, 0,  0, 0, 0, 0, K_NONE, 0, 0, 0);
        // both valid from reset: req0 bursts 8, then req1 bursts 8, alternating
        add(1, 1, 1, 1, 8, 0, 0, K_NONE, 0, 0, 0);
        add(0, 1, 1, 1, 8, 0, 0, K_NONE, 0, 0, 0);
        add(0, 1, 1, 1, 8, 0, 1, K_MASK, 0, 0, 0);
        for (int k = 2; k <= 8; k++) add(0, 1, k, 1, 8, 0, 1, K_INC, 0, 0, 0);
        add(0, 1, 9, 1, 12, 0, 2, K_MASK, 1, 0, 0);
        for (int k = 11; k >= 5; k--) add(0, 1, 9, 1, k, 0, 2, K_DEC, 1, 0, 0);
        add(0, 1, 9,  1, 4, 0, 1, K_MASK, 0, 0, 0);
        add(0, 1, 10, 1, 4, 0, 1, K_INC,  0, 0, 0);
        add(0, 0, 0,  1, 4, 0, 1, K_NONE, 0, 0, 0);
        add(0, 0, 0,  1, 4, 0, 2, K_MASK, 1, 0, 0);
        add(0, 0, 0,  0, 0, 0, 2, K_NONE, 0, 0, 0);
        // reset mid-burst with a nonzero error count
        add(0, 1, 2,  0, 0, 0, 0, K_NONE, 0, 0, 0);
        add(0, 1, 2,  0, 0, 0, 1, K_MASK, 0, 0, 0);
        add(0, 1, 9,  0, 0, 0, 1, K_ERR,  0, 0, 0);
        add(0, 1, 10, 0, 0, 0, 1, K_INC,  0, 0, 0);
        add(0, 1, 11, 0, 0, 0, 1, K_INC,  0, 1, 0);
        add(1, 1, 12, 0, 0, 0, 0, K_NONE, 0, 0, 0);
        add(0, 1, 12, 0, 0, 0, 0, K_NONE, 0, 0, 0);
        add(0, 1, 13, 0, 0, 0, 1, K_MASK, 0, 0, 0);
        add(0, 1, 14, 0, 0, 0, 1, K_INC,  0, 0, 0);
        add(0, 0, 0,  0, 0, 0, 1, K_NONE, 0, 0, 0);
        add(0, 0, 0,  0, 0, 0, 0, K_NONE, 0, 0, 0);
        // burst exhaustion with req0 alone: same-owner re-grant, ninth beat not masked
        add(0, 1, 13, 0, 0, 0, 0, K_NONE, 0, 0, 0);
        for (int k = 13; k >= 6; k--) add(0, 1, k, 0, 0, 0, 1, K_DEC, 0, 0, 0);
        add(0, 1, 5,  0, 0, 0, 1, K_DEC,  0, 0, 0);
        add(0, 0, 0,  0, 0, 0, 1, K_NONE, 0, 0, 0);
        add(0, 0, 0,  0, 0, 0, 0, K_NONE, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            cur_row = i;
            apply(vecs[i]);
        end

        // Saturation: req1 streams alternating 0/15 so every unmasked beat is an error
        cur_row = 1000;
        @(negedge clk);
        reset = 1'b1; req0_valid = 0; req1_valid = 0; err_clr = 0;
        @(negedge clk);
        reset = 1'b0;
        tog = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            req1_valid = 1'b1;
            req1_data  = tog ? 4'd15 : 4'd0;
            tog = ~tog;
        end
        #1;
        check("err_cnt1_saturated", int'(err_cnt1), 255);
        check("err_cnt0_untouched", int'(err_cnt0), 0);
        @(negedge clk);
        req1_data = tog ? 4'd15 : 4'd0; tog = ~tog;
        err_clr = 1'b1;
        #1;
        check("error_alongside_clr", int'(res_valid & res_error), 1);
        @(negedge clk);
        req1_data = tog ? 4'd15 : 4'd0; tog = ~tog;
        err_clr = 1'b0;
        #1;
        check("err_cnt1_after_clr", int'(err_cnt1), 0);
        @(negedge clk);
        req1_data = tog ? 4'd15 : 4'd0; tog = ~tog;
        #1;
        check("err_cnt1_recount", int'(err_cnt1), 1);
        @(negedge clk);
        req1_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
